wb_src_arbiter: RTL and testbench

//  Round-robin arbiter sharing one WIDTH-bit writeback result bus among 4 producers
//  (ALU, shifter, load unit, mult/div) via valid/ready handshakes.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 44 ++++
 rtl/wb_src_arbiter.sv | 105 ++++++++++
 tb/tb_wb_src_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback source arbiter.
//   NUM_SRC / SRC_W : number of result producers and width of a source index
//   SRC_*           : fixed source index assignment on the result bus
//   wb_state_e      : output-buffer occupancy state
package wb_pkg;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned SRC_W   = 2;

   localparam logic [SRC_W-1:0] SRC_ALU   = 2'd0;
   localparam logic [SRC_W-1:0] SRC_SHIFT = 2'd1;
   localparam logic [SRC_W-1:0] SRC_LOAD  = 2'd2;
   localparam logic [SRC_W-1:0] SRC_MDU   = 2'd3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } wb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way grant picker.
//   req       : request vector, bit i = source i wants the bus
//   last      : most recently granted source (round-robin pointer)
//   mode      : 0 = round-robin starting after last, 1 = fixed priority (source 0 highest)
//   gnt_valid : some request is set
//   gnt_idx   : index of the chosen source (0 when gnt_valid is low)
module rr_pick4
   import wb_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   last,
   input  logic               mode,
   output logic               gnt_valid,
   output logic [SRC_W-1:0]   gnt_idx
);

   logic [SRC_W-1:0] cand;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      if (mode) begin
         // Descending scan so the lowest set bit is the last one written.
         for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
               gnt_valid = 1'b1;
               gnt_idx   = SRC_W'(i);
            end
         end
      end else begin
         // Offsets 4..1 scanned downward: offset 4 wraps to last itself and has the
         // lowest precedence, offset 1 (the source right after last) the highest.
         for (int k = NUM_SRC; k >= 1; k--) begin
            cand = last + SRC_W'(k);
            if (req[cand]) begin
               gnt_valid = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
   end

endmodule

// File: rtl/wb_src_arbiter.sv
// Writeback result-bus arbiter: four producers (ALU, shifter, load, mult/div) compete via
// valid/ready for a single registered output word feeding the register-file write port.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready : per-source handshake; req_ready is one-hot or zero
//   req_data0..3        : per-source result words
//   out_valid/out_ready : output-buffer handshake toward the register file
//   out_data, out_src   : buffered word and the index of the source that produced it
module wb_src_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] req_valid,
   input  logic [WIDTH-1:0]   req_data0,
   input  logic [WIDTH-1:0]   req_data1,
   input  logic [WIDTH-1:0]   req_data2,
   input  logic [WIDTH-1:0]   req_data3,
   output logic [NUM_SRC-1:0] req_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SRC_W-1:0]   out_src,
   input  logic               out_ready
);

   wb_state_e        state_q, state_d;
   logic [SRC_W-1:0] last_q, last_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SRC_W-1:0] src_q, src_d;

   logic             gnt_valid;
   logic [SRC_W-1:0] gnt_idx;
   logic [WIDTH-1:0] sel_data;
   logic             can_load;
   logic             grant_ok;
   logic             xfer;

   rr_pick4 u_pick (
      .req       (req_valid),
      .last      (last_q),
      .mode      (PRIO_MODE != 0),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      sel_data = '0;
      unique case (gnt_idx)
         SRC_ALU:   sel_data = req_data0;
         SRC_SHIFT: sel_data = req_data1;
         SRC_LOAD:  sel_data = req_data2;
         SRC_MDU:   sel_data = req_data3;
      endcase
   end

   // The buffer can take a word if it is empty or is being drained this same cycle.
   assign can_load = (state_q == EMPTY) | out_ready;
   // Reset is in the term so no source sees an acceptance while the buffer is held clear.
   assign grant_ok = can_load & gnt_valid & ~reset;
   assign xfer     = grant_ok & req_valid[gnt_idx];

   always_comb begin
      req_ready = '0;
      if (grant_ok) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      data_d  = data_q;
      src_d   = src_q;
      if (xfer) begin
         state_d = FULL;
         last_d  = gnt_idx;
         data_d  = sel_data;
         src_d   = gnt_idx;
      end else if ((state_q == FULL) && out_ready) begin
         // Drained with nothing to replace it: data/src keep their last values.
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         last_q  <= SRC_MDU;  // next pick starts at source 0
         data_q  <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule

// File: tb/tb_wb_src_arbiter.sv
module tb_wb_src_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   // Round-robin instance
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data [4];
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_src;
   logic        out_ready = 1'b0;

   // Fixed-priority instance
   logic [3:0]  p_req_valid = '0;
   logic [31:0] p_req_data [4];
   logic [3:0]  p_req_ready;
   logic        p_out_valid;
   logic [31:0] p_out_data;
   logic [1:0]  p_out_src;
   logic        p_out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_src_arbiter #(.WIDTH(32), .PRIO_MODE(0)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data0 (req_data[0]),
      .req_data1 (req_data[1]),
      .req_data2 (req_data[2]),
      .req_data3 (req_data[3]),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   wb_src_arbiter #(.WIDTH(32), .PRIO_MODE(1)) u_dut_prio (
      .clk       (clk),
      .reset     (reset),
      .req_valid (p_req_valid),
      .req_data0 (p_req_data[0]),
      .req_data1 (p_req_data[1]),
      .req_data2 (p_req_data[2]),
      .req_data3 (p_req_data[3]),
      .req_ready (p_req_ready),
      .out_valid (p_out_valid),
      .out_data  (p_out_data),
      .out_src   (p_out_src),
      .out_ready (p_out_ready)
   );

   // Reference pick: returns {found, index}.
   function automatic logic [2:0] pick(input logic [3:0] req, input int last, input bit prio);
      if (prio) begin
         for (int i = 0; i < 4; i++) if (req[i]) return {1'b1, 2'(i)};
      end else begin
         for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (req[idx]) return {1'b1, 2'(idx)};
         end
      end
      return 3'b000;
   endfunction

   task automatic reset_dut();
      reset       = 1'b1;
      req_valid   = '0;
      p_req_valid = '0;
      out_ready   = 1'b0;
      p_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i] = $urandom;
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++;
         $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (out_src !== 2'd0) begin errors++;
         $display("FAIL reset_out_src got %0d want 0", out_src); end
      checks++; if (req_ready !== 4'b0000) begin errors++;
         $display("FAIL reset_req_ready got %b want 0000", req_ready); end
      reset_dut();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      for (int i = 0; i < 4; i++) req_data[i] = $urandom;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL mid_reset_out_valid got %b want 0", out_valid); end
      checks++; if (req_ready !== 4'b0000) begin errors++;
         $display("FAIL mid_reset_req_ready got %b want 0000", req_ready); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin errors++;
         $display("FAIL mid_reset_first_grant got %b want 0001", req_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== req_data[0]) begin
         errors++;
         $display("FAIL mid_reset_first_word got v=%b src=%0d d=%h want v=1 src=0 d=%h",
                  out_valid, out_src, out_data, req_data[0]);
      end
   endtask

   task automatic test_single();
      reset_dut();
      req_valid   = 4'b0100;
      req_data[2] = 32'hDEADBEEF;
      out_ready   = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin errors++;
         $display("FAIL single_req_ready got %b want 0100", req_ready); end
      @(posedge clk);
      #1 req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 2'd2) begin
         errors++;
         $display("FAIL single_out got v=%b d=%h src=%0d want v=1 d=deadbeef src=2",
                  out_valid, out_data, out_src);
      end
   endtask

   task automatic test_round_robin();
      reset_dut();
      for (int i = 0; i < 4; i++) req_data[i] = $urandom;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== req_data[k % 4]) begin
            errors++;
            $display("FAIL rr_seq[%0d] got v=%b src=%0d d=%h want v=1 src=%0d d=%h",
                     k, out_valid, out_src, out_data, k % 4, req_data[k % 4]);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] w1;
      reset_dut();
      w1 = $urandom;
      for (int i = 0; i < 4; i++) req_data[i] = $urandom;
      req_data[1] = w1;
      req_valid   = 4'b0010;
      out_ready   = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 4'b1111;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_src !== 2'd1 ||
             out_data !== w1) begin
            errors++;
            $display("FAIL stall[%0d] got rdy=%b v=%b src=%0d d=%h want rdy=0000 v=1 src=1 d=%h",
                     c, req_ready, out_valid, out_src, out_data, w1);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin errors++;
         $display("FAIL stall_resume_grant got %b want 0100", req_ready); end
      @(negedge clk);
      checks++; if (out_src !== 2'd2 || out_data !== req_data[2]) begin errors++;
         $display("FAIL stall_resume_word got src=%0d d=%h want src=2 d=%h",
                  out_src, out_data, req_data[2]); end
   endtask

   task automatic test_drain();
      logic [31:0] w;
      reset_dut();
      w           = $urandom;
      req_data[0] = w;
      req_valid   = 4'b0001;
      out_ready   = 1'b1;
      @(posedge clk);
      #1 req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== w) begin errors++;
         $display("FAIL drain_load got v=%b d=%h want v=1 d=%h", out_valid, out_data, w); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== w || out_src !== 2'd0 || req_ready !== 4'b0000)
      begin
         errors++;
         $display("FAIL drain_empty got v=%b d=%h src=%0d rdy=%b want v=0 d=%h src=0 rdy=0000",
                  out_valid, out_data, out_src, req_ready, w);
      end
   endtask

   task automatic test_prio();
      reset_dut();
      for (int i = 0; i < 4; i++) p_req_data[i] = $urandom;
      p_req_valid = 4'b1010;
      p_out_ready = 1'b1;
      @(negedge clk);
      checks++; if (p_req_ready !== 4'b0010) begin errors++;
         $display("FAIL prio_req_ready got %b want 0010", p_req_ready); end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (p_out_valid !== 1'b1 || p_out_src !== 2'd1) begin errors++;
            $display("FAIL prio_hold[%0d] got v=%b src=%0d want v=1 src=1",
                     k, p_out_valid, p_out_src); end
      end
      @(posedge clk);
      #1 p_req_valid = 4'b1000;
      @(negedge clk);
      checks++; if (p_req_ready !== 4'b1000) begin errors++;
         $display("FAIL prio_drop_ready got %b want 1000", p_req_ready); end
      @(negedge clk);
      checks++; if (p_out_src !== 2'd3 || p_out_data !== p_req_data[3]) begin errors++;
         $display("FAIL prio_drop_src got src=%0d d=%h want src=3 d=%h",
                  p_out_src, p_out_data, p_req_data[3]); end
   endtask

   // Random traffic against a transaction-level model of the buffer and pick order.
   task automatic test_random(input int n);
      logic [3:0]  pend;
      logic [31:0] word [4];
      int          waits [4];
      bit          m_valid;
      logic [31:0] m_data;
      logic [1:0]  m_src;
      int          m_last;
      logic [2:0]  p;
      logic [3:0]  exp_rdy;
      bit          can;
      reset_dut();
      pend    = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
      m_last  = 3;
      for (int i = 0; i < 4; i++) begin waits[i] = 0; word[i] = '0; end
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               word[i] = $urandom;
            end
            req_data[i] = word[i];
         end
         req_valid = pend;
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         can     = !m_valid || out_ready;
         p       = pick(pend, m_last, 1'b0);
         exp_rdy = (can && p[2]) ? (4'b0001 << p[1:0]) : 4'b0000;
         checks++; if (req_ready !== exp_rdy) begin errors++;
            $display("FAIL rand_ready[%0d] got %b want %b", t, req_ready, exp_rdy); end
         checks++; if (out_valid !== m_valid) begin errors++;
            $display("FAIL rand_valid[%0d] got %b want %b", t, out_valid, m_valid); end
         checks++; if (out_data !== m_data || out_src !== m_src) begin errors++;
            $display("FAIL rand_word[%0d] got d=%h src=%0d want d=%h src=%0d",
                     t, out_data, out_src, m_data, m_src); end
         @(posedge clk);
         if (exp_rdy != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (i != int'(p[1:0]) && pend[i]) waits[i]++;
            checks++; if (waits[p[1:0]] > 3) begin errors++;
               $display("FAIL rand_fairness[%0d] src=%0d waited %0d want <=3",
                        t, p[1:0], waits[p[1:0]]); end
            waits[p[1:0]] = 0;
            pend[p[1:0]]  = 1'b0;
            m_valid       = 1'b1;
            m_data        = word[p[1:0]];
            m_src         = p[1:0];
            m_last        = int'(p[1:0]);
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         req_data[i]   = '0;
         p_req_data[i] = '0;
      end
      test_reset();
      test_reset_mid();
      test_single();
      test_round_robin();
      test_stall();
      test_drain();
      test_prio();
      test_random(400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
